// File: rtl/v7458_exhaustive_tester_if.sv
// Stimulus/response and result bundle between the exhaustive tester and the
// gate block plus its supervisor.
interface v7458_exhaustive_tester_if;
  localparam int unsigned VEC_W = 10;
  localparam int unsigned ERR_W = 11;

  logic             start;
  logic [VEC_W-1:0] vec;
  logic             m_in;
  logic             n_in;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic [VEC_W-1:0] first_err_vec;
  logic             first_err_valid;

  modport master (
    input  start, m_in, n_in,
    output vec, busy, done, pass, err_count, first_err_vec, first_err_valid
  );

  modport slave (
    output start, m_in, n_in,
    input  vec, busy, done, pass, err_count, first_err_vec, first_err_valid
  );
endinterface

// File: rtl/v7458_exhaustive_tester.sv
// Walks all 1024 input vectors of a 7458 dual AND-OR gate, compares the two
// gate outputs with a golden model and reports error count, first failure and pass.
module v7458_exhaustive_tester #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  v7458_exhaustive_tester_if.master   bus
);
  localparam int unsigned VEC_W = 10;
  localparam int unsigned ERR_W = 11;
  localparam int unsigned CNT_W = 8;

  localparam logic [VEC_W-1:0] VEC_LAST    = VEC_W'(1023);
  localparam logic [ERR_W-1:0] ERR_MAX     = ERR_W'(1024);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [VEC_W-1:0] ferr_vec_q, ferr_vec_d;
  logic             ferr_valid_q, ferr_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;

  logic exp_m_c;
  logic exp_n_c;
  logic mismatch_c;

  // Golden model of both gate sections for the vector currently driven.
  always_comb begin
    exp_m_c    = (vec_q[9] & vec_q[8] & vec_q[7]) | (vec_q[6] & vec_q[5] & vec_q[4]);
    exp_n_c    = (vec_q[3] & vec_q[2]) | (vec_q[1] & vec_q[0]);
    mismatch_c = (bus.m_in != exp_m_c) || (bus.n_in != exp_n_c);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      vec_q        <= '0;
      cnt_q        <= '0;
      err_q        <= '0;
      ferr_vec_q   <= '0;
      ferr_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      ferr_vec_q   <= ferr_vec_d;
      ferr_valid_q <= ferr_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    vec_d        = vec_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    ferr_vec_d   = ferr_vec_q;
    ferr_valid_d = ferr_valid_q;
    busy_d       = busy_q;
    done_d       = done_q;
    pass_d       = pass_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_d      = ST_SETTLE;
          vec_d        = '0;
          cnt_d        = '0;
          err_d        = '0;
          ferr_vec_d   = '0;
          ferr_valid_d = 1'b0;
          busy_d       = 1'b1;
          done_d       = 1'b0;
          pass_d       = 1'b0;
        end
      end

      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = ST_CHECK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_CHECK: begin
        if (mismatch_c) begin
          if (err_q != ERR_MAX) begin
            err_d = err_q + ERR_W'(1);
          end
          if (!ferr_valid_q) begin
            ferr_vec_d   = vec_q;
            ferr_valid_d = 1'b1;
          end
        end
        // Last vector closes the run; pass reflects the final count including this check.
        if (vec_q == VEC_LAST) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
        end else begin
          state_d = ST_SETTLE;
          vec_d   = vec_q + VEC_W'(1);
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.vec             = vec_q;
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.pass            = pass_q;
  assign bus.err_count       = err_q;
  assign bus.first_err_vec   = ferr_vec_q;
  assign bus.first_err_valid = ferr_valid_q;
endmodule

// File: tb/tb_v7458_exhaustive_tester.sv
// Directed bench: a behavioural 7458 with selectable faults feeds the tester;
// results are compared against hand-derived counts and first-failure vectors.
module tb_v7458_exhaustive_tester;
  logic clk;
  logic rst;
  int   fault;
  int   checks;
  int   errors;
  int   cyc;
  int   order_bad;
  logic [9:0] prev_vec;

  v7458_exhaustive_tester_if bus_a ();
  v7458_exhaustive_tester_if bus_b ();

  v7458_exhaustive_tester #(.SETTLE_CYCLES(2)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  v7458_exhaustive_tester #(.SETTLE_CYCLES(1)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic gate_m(input logic [9:0] v);
    return (v[9] & v[8] & v[7]) | (v[6] & v[5] & v[4]);
  endfunction

  function automatic logic gate_n(input logic [9:0] v);
    return (v[3] & v[2]) | (v[1] & v[0]);
  endfunction

  // fault: 0 good, 1 m stuck at 0, 2 n stuck at 0, 3 n inverted
  always_comb begin
    bus_a.m_in = (fault == 1) ? 1'b0 : gate_m(bus_a.vec);
    bus_a.n_in = (fault == 2) ? 1'b0 : (fault == 3) ? ~gate_n(bus_a.vec) : gate_n(bus_a.vec);
    bus_b.m_in = gate_m(bus_b.vec);
    bus_b.n_in = gate_n(bus_b.vec);
  end

  // Vector sequence must step by one (or restart at 0) while busy.
  always @(negedge clk) begin
    if (rst) begin
      prev_vec <= '0;
    end else begin
      if (bus_a.busy && bus_a.vec != prev_vec && bus_a.vec != 10'(prev_vec + 10'd1)
          && bus_a.vec != 10'd0)
        order_bad <= order_bad + 1;
      prev_vec <= bus_a.vec;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic start_a();
    @(negedge clk);
    bus_a.start = 1'b1;
    @(posedge clk);
    #1 bus_a.start = 1'b0;
  endtask

  task automatic wait_done_a(input int cap, input int c0, output int cycles);
    cycles = c0;
    while (cycles <= cap && !bus_a.done) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic check_result_a(input string tag, input int exp_err, input int exp_fev,
                                input int exp_fvalid);
    check_val({tag, "_done"}, 32'(bus_a.done), 32'd1);
    check_val({tag, "_busy"}, 32'(bus_a.busy), 32'd0);
    check_val({tag, "_vec"}, 32'(bus_a.vec), 32'd1023);
    check_val({tag, "_err"}, 32'(bus_a.err_count), 32'(exp_err));
    check_val({tag, "_fev"}, 32'(bus_a.first_err_vec), 32'(exp_fev));
    check_val({tag, "_fvalid"}, 32'(bus_a.first_err_valid), 32'(exp_fvalid));
    check_val({tag, "_pass"}, 32'(bus_a.pass), 32'(exp_err == 0));
  endtask

  task automatic check_reset_a(input string tag);
    check_val({tag, "_vec"}, 32'(bus_a.vec), 32'd0);
    check_val({tag, "_busy"}, 32'(bus_a.busy), 32'd0);
    check_val({tag, "_done"}, 32'(bus_a.done), 32'd0);
    check_val({tag, "_pass"}, 32'(bus_a.pass), 32'd0);
    check_val({tag, "_err"}, 32'(bus_a.err_count), 32'd0);
    check_val({tag, "_fev"}, 32'(bus_a.first_err_vec), 32'd0);
    check_val({tag, "_fvalid"}, 32'(bus_a.first_err_valid), 32'd0);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    order_bad   = 0;
    fault       = 0;
    rst         = 1'b1;
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_reset_a("rst");
    check_val("rst_b_busy", 32'(bus_b.busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Good gate, default settle time
    fault = 0;
    start_a();
    check_val("good_start_busy", 32'(bus_a.busy), 32'd1);
    check_val("good_start_vec", 32'(bus_a.vec), 32'd0);
    wait_done_a(3200, 0, cyc);
    check_val("good_cycles", 32'(cyc), 32'd3072);
    check_result_a("good", 0, 0, 0);

    // m stuck low: 15 of 64 a-f patterns drive m high, times 16 g-j patterns
    fault = 1;
    start_a();
    check_val("restart_err_clear", 32'(bus_a.err_count), 32'd0);
    check_val("restart_done_clear", 32'(bus_a.done), 32'd0);
    check_val("restart_busy", 32'(bus_a.busy), 32'd1);
    wait_done_a(3200, 0, cyc);
    check_val("m0_cycles", 32'(cyc), 32'd3072);
    check_result_a("m0", 240, 'h070, 1);

    // n stuck low: 7 of 16 g-j patterns drive n high, times 64
    fault = 2;
    start_a();
    check_val("n0_fvalid_clear", 32'(bus_a.first_err_valid), 32'd0);
    wait_done_a(3200, 0, cyc);
    check_result_a("n0", 448, 'h003, 1);

    // n inverted: every vector fails, count saturates exactly at 1024
    fault = 3;
    start_a();
    wait_done_a(3200, 0, cyc);
    check_result_a("ninv", 1024, 0, 1);

    // start during a run is ignored
    fault = 0;
    start_a();
    repeat (499) @(posedge clk);
    @(negedge clk);
    bus_a.start = 1'b1;
    @(posedge clk);
    #1 bus_a.start = 1'b0;
    check_val("midstart_vec", 32'(bus_a.vec), 32'd166);
    wait_done_a(3200, 500, cyc);
    check_val("midstart_cycles", 32'(cyc), 32'd3072);
    check_result_a("midstart", 0, 0, 0);

    // async reset mid-run discards partial results
    fault = 3;
    start_a();
    repeat (100) @(posedge clk);
    #2;
    check_val("prerst_err", 32'(bus_a.err_count), 32'd33);
    rst = 1'b1;
    #1;
    check_reset_a("midrst");
    @(negedge clk);
    rst = 1'b0;
    fault = 0;
    start_a();
    wait_done_a(3200, 0, cyc);
    check_val("postrst_cycles", 32'(cyc), 32'd3072);
    check_result_a("postrst", 0, 0, 0);

    // SETTLE_CYCLES=1 instance
    @(negedge clk);
    bus_b.start = 1'b1;
    @(posedge clk);
    #1 bus_b.start = 1'b0;
    cyc = 0;
    while (cyc <= 2200 && !bus_b.done) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check_val("s1_cycles", 32'(cyc), 32'd2048);
    check_val("s1_pass", 32'(bus_b.pass), 32'd1);
    check_val("s1_err", 32'(bus_b.err_count), 32'd0);
    check_val("s1_vec", 32'(bus_b.vec), 32'd1023);

    check_val("vec_order", 32'(order_bad), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
